alarm_scheduler: RTL and testbench
==================================

// Module: alarm_scheduler
// PURPOSE
//  Sequences the alarm function of the alarm clock. Compares running HH:MM time against two stored alarms,
//  then drives the buzzer through IDLE/RING/SNOOZE with ring timeout and snooze limit.
//  Sits beside the timekeeping/display datapath; consumes its BCD digits and 1 Hz/minute strobes.
// PARAMETERS
//  RING_SECS   60  seconds RING lasts without user action before auto-dismiss (1..255)
//  SNOOZE_MIN  9   minutes spent in SNOOZE before re-ringing (1..63)
//  MAX_SNOOZE  3   snoozes honoured per alarm event; further snooze presses act as dismiss (0..7)
// PORTS
//  clock     in   1   system clock; all state changes on posedge
//  reset     in   1   synchronous, active-high reset
//  sec_tick  in   1   one-cycle strobe, once per second
//  min_tick  in   1   one-cycle strobe, once per minute (coincides with a sec_tick)
//  time_bcd  in   16  {h10,h1,m10,m1} current time, 24 h BCD
//  alarm1    in   16  {h10,h1,m10,m1} alarm 1, 24 h BCD
//  alarm2    in   16  {h10,h1,m10,m1} alarm 2, 24 h BCD
//  alm_en    in   2   bit0 enables alarm 1, bit1 enables alarm 2
//  snooze    in   1   level, debounced; rising edge detected internally
//  dismiss   in   1   level, debounced; rising edge detected internally
//  buzz      out  1   buzzer drive
//  ring_id   out  2   01 alarm1, 10 alarm2, 00 none; valid in RING and SNOOZE
//  snoozing  out  1   high in SNOOZE
// BEHAVIOUR
//  Reset: state=IDLE; buzz=0, ring_id=00, snoozing=0; counters, fired flags, edge regs all 0.
//  Match: alarm k matches when alm_en[k] && time_bcd==alarmk && !fired[k]; full 16-bit equality, no BCD checking.
//    An alarm holding an invalid time (e.g. 25:00) never matches.
//  fired[k] is set when alarm k matches, whatever the FSM state; cleared on any cycle time_bcd!=alarmk.
//    Result: one event per matching minute, never retriggered within it.
//  IDLE: match -> RING next cycle; buzz=1 on the cycle after time_bcd first equals the alarm (1-cycle latency).
//    If both alarms match the same cycle, alarm 1 wins (ring_id=01) and both set fired; alarm 2 is not queued.
//  RING: buzz=1 every cycle, sec_cnt increments on sec_tick.
//    Rising edge of dismiss -> IDLE.
//    Rising edge of snooze with snz_cnt<MAX_SNOOZE -> SNOOZE, snz_cnt+1.
//    Rising edge of snooze with snz_cnt==MAX_SNOOZE -> IDLE (treated as dismiss).
//    sec_cnt reaching RING_SECS -> IDLE.
//    On entry to RING, sec_cnt=0.
//  SNOOZE: buzz=0, snoozing=1; min_cnt increments on min_tick.
//    min_cnt==SNOOZE_MIN -> RING (sec_cnt=0, same ring_id).
//    Rising edge of dismiss -> IDLE.
//    On entry to SNOOZE, min_cnt=0.
//  On any entry to IDLE: ring_id=00, snz_cnt=0, sec_cnt=0, min_cnt=0.
//  Precedence within one cycle: reset > disable of active alarm > dismiss > timeout/snooze expiry > snooze.
//  Active alarm disabled (alm_en bit cleared) during RING/SNOOZE -> IDLE next cycle.
//  Match of the other alarm during RING/SNOOZE is dropped; its fired flag is still set.
//  Edits to alarmk while it is active do not change the state; only the enable bit cancels.
//  Counter widths: sec_cnt 8b, min_cnt 6b, snz_cnt 3b; counters saturate, never wrap.
//  Midnight wrap (23:59 -> 00:00) needs no special case; 00:00 alarms match normally.
//  Reset asserted mid-RING or mid-SNOOZE: buzz=0 on the next edge; reset holds everything at reset values.
// STRUCTURE
//  alarm_defs.vh (shared): state encodings ST_IDLE=2'd0, ST_RING=2'd1, ST_SNOOZE=2'd2; ring_id codes;
//    BCD digit field offsets for {h10,h1,m10,m1}.
//  Sub-module alarm_match (instantiated twice): compare, enable, fired flag; outputs one-cycle hit.
//  The top level holds the FSM, the three counters and the two button edge detectors.
// TESTING
//  1 alarm1=07:30, en=01, step time 07:29->07:30 -> buzz=1, ring_id=01 one cycle later; held for 60 sec_ticks, then 0.
//  2 RING, snooze edge -> snoozing=1, buzz=0; after 9 min_ticks -> buzz=1 again; repeat 3x, 4th snooze -> IDLE.
//  3 alarm1=alarm2=06:00, both enabled -> ring_id=01; after dismiss, no alarm2 ring in minute 06:00.
//  4 Dismiss during RING -> IDLE next cycle; time held at match value -> no retrigger; 06:01->06:00 (manual set) -> rings.
//  5 snooze and dismiss rising the same cycle -> IDLE; clear alm_en[0] during SNOOZE -> IDLE, ring_id=00.
//  6 reset pulsed mid-RING -> buzz=0, all outputs 0 next edge; alarm 23:59 -> 00:00 rollover with alarm2=00:00 rings.

Source files
------------

// File: rtl/alarm_scheduler_pkg.sv
// Shared types and constants for the alarm scheduler.
// Holds the FSM state encoding, ring_id codes and the counter and time-bus widths.
package alarm_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RING   = 2'd1,
        ST_SNOOZE = 2'd2
    } state_e;

    localparam logic [1:0] RID_NONE = 2'b00;
    localparam logic [1:0] RID_A1   = 2'b01;
    localparam logic [1:0] RID_A2   = 2'b10;

    localparam int unsigned TIME_W = 16;   // {h10,h1,m10,m1} BCD
    localparam int unsigned SEC_W  = 8;
    localparam int unsigned MIN_W  = 6;
    localparam int unsigned SNZ_W  = 3;

endpackage

// File: rtl/alarm_scheduler_if.sv
// Bundle of the scheduler's time, alarm, button and buzzer signals.
//  master: drives the strobes, time, alarms, enables and buttons; observes the outputs.
//  slave : the scheduler, which drives buzz, ring_id and snoozing.
interface alarm_scheduler_if;
    import alarm_scheduler_pkg::*;

    logic              sec_tick;
    logic              min_tick;
    logic [TIME_W-1:0] time_bcd;
    logic [TIME_W-1:0] alarm1;
    logic [TIME_W-1:0] alarm2;
    logic [1:0]        alm_en;
    logic              snooze;
    logic              dismiss;
    logic              buzz;
    logic [1:0]        ring_id;
    logic              snoozing;

    modport master (
        output sec_tick, min_tick, time_bcd, alarm1, alarm2, alm_en, snooze, dismiss,
        input  buzz, ring_id, snoozing
    );

    modport slave (
        input  sec_tick, min_tick, time_bcd, alarm1, alarm2, alm_en, snooze, dismiss,
        output buzz, ring_id, snoozing
    );

endinterface

// File: rtl/alarm_match.sv
// Compares the running time with one stored alarm.
// Ports:
//  clock, reset   system clock and synchronous active-high reset
//  en             alarm enable
//  time_bcd       current time
//  alarm          stored alarm time
//  hit_c          single-cycle strobe on the first matching cycle of a minute
module alarm_match
    import alarm_scheduler_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              en,
    input  logic [TIME_W-1:0] time_bcd,
    input  logic [TIME_W-1:0] alarm,
    output logic              hit_c
);

    logic eq_c;
    logic fired_d;
    logic fired_q;

    // fired stays set while the time equals the alarm, so each matching minute yields one hit
    always_comb begin
        eq_c    = (time_bcd == alarm);
        hit_c   = en && eq_c && !fired_q;
        fired_d = eq_c && (fired_q || hit_c);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fired_q <= 1'b0;
        end else begin
            fired_q <= fired_d;
        end
    end

endmodule

// File: rtl/alarm_scheduler.sv
// Alarm sequencer: IDLE/RING/SNOOZE FSM with a ring timeout, snooze timer and snooze limit.
// Ports:
//  clock, reset   system clock and synchronous active-high reset
//  bus (slave)    strobes, time, alarms, enables, buttons in; buzz, ring_id, snoozing out
module alarm_scheduler
    import alarm_scheduler_pkg::*;
#(
    parameter int unsigned RING_SECS  = 60,
    parameter int unsigned SNOOZE_MIN = 9,
    parameter int unsigned MAX_SNOOZE = 3
) (
    input logic               clock,
    input logic               reset,
    alarm_scheduler_if.slave  bus
);

    state_e           state_q, state_d;
    logic [SEC_W-1:0] sec_cnt_q, sec_cnt_d, sec_inc_c;
    logic [MIN_W-1:0] min_cnt_q, min_cnt_d, min_inc_c;
    logic [SNZ_W-1:0] snz_cnt_q, snz_cnt_d;
    logic [1:0]       ring_id_q, ring_id_d;
    logic             buzz_q, buzz_d;
    logic             snoozing_q, snoozing_d;
    logic             snooze_q, snooze_d;
    logic             dismiss_q, dismiss_d;
    logic             hit1_c, hit2_c;
    logic             snz_rise_c, dis_rise_c, act_en_c, go_idle_c;

    alarm_match u_match1 (
        .clock    (clock),
        .reset    (reset),
        .en       (bus.alm_en[0]),
        .time_bcd (bus.time_bcd),
        .alarm    (bus.alarm1),
        .hit_c    (hit1_c)
    );

    alarm_match u_match2 (
        .clock    (clock),
        .reset    (reset),
        .en       (bus.alm_en[1]),
        .time_bcd (bus.time_bcd),
        .alarm    (bus.alarm2),
        .hit_c    (hit2_c)
    );

    // Next state, counters and registered outputs
    always_comb begin
        state_d    = state_q;
        sec_cnt_d  = sec_cnt_q;
        min_cnt_d  = min_cnt_q;
        snz_cnt_d  = snz_cnt_q;
        ring_id_d  = ring_id_q;
        go_idle_c  = 1'b0;
        snooze_d   = bus.snooze;
        dismiss_d  = bus.dismiss;

        snz_rise_c = bus.snooze && !snooze_q;
        dis_rise_c = bus.dismiss && !dismiss_q;
        act_en_c   = (ring_id_q == RID_A2) ? bus.alm_en[1] : bus.alm_en[0];
        // saturating increments
        sec_inc_c  = (&sec_cnt_q) ? sec_cnt_q : sec_cnt_q + SEC_W'(bus.sec_tick);
        min_inc_c  = (&min_cnt_q) ? min_cnt_q : min_cnt_q + MIN_W'(bus.min_tick);

        case (state_q)
            ST_IDLE: begin
                // alarm 1 wins a simultaneous match; alarm 2 is not queued
                if (hit1_c) begin
                    state_d   = ST_RING;
                    ring_id_d = RID_A1;
                    sec_cnt_d = '0;
                end else if (hit2_c) begin
                    state_d   = ST_RING;
                    ring_id_d = RID_A2;
                    sec_cnt_d = '0;
                end
            end
            ST_RING: begin
                sec_cnt_d = sec_inc_c;
                if (!act_en_c || dis_rise_c) begin
                    go_idle_c = 1'b1;
                end else if (sec_inc_c == SEC_W'(RING_SECS)) begin
                    go_idle_c = 1'b1;
                end else if (snz_rise_c) begin
                    if (snz_cnt_q < SNZ_W'(MAX_SNOOZE)) begin
                        state_d   = ST_SNOOZE;
                        snz_cnt_d = snz_cnt_q + SNZ_W'(1);
                        min_cnt_d = '0;
                    end else begin
                        go_idle_c = 1'b1;
                    end
                end
            end
            ST_SNOOZE: begin
                min_cnt_d = min_inc_c;
                if (!act_en_c || dis_rise_c) begin
                    go_idle_c = 1'b1;
                end else if (min_inc_c == MIN_W'(SNOOZE_MIN)) begin
                    state_d   = ST_RING;
                    sec_cnt_d = '0;
                end
            end
            default: go_idle_c = 1'b1;
        endcase

        if (go_idle_c) begin
            state_d   = ST_IDLE;
            ring_id_d = RID_NONE;
            sec_cnt_d = '0;
            min_cnt_d = '0;
            snz_cnt_d = '0;
        end

        buzz_d     = (state_d == ST_RING);
        snoozing_d = (state_d == ST_SNOOZE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            sec_cnt_q  <= '0;
            min_cnt_q  <= '0;
            snz_cnt_q  <= '0;
            ring_id_q  <= RID_NONE;
            buzz_q     <= 1'b0;
            snoozing_q <= 1'b0;
            snooze_q   <= 1'b0;
            dismiss_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sec_cnt_q  <= sec_cnt_d;
            min_cnt_q  <= min_cnt_d;
            snz_cnt_q  <= snz_cnt_d;
            ring_id_q  <= ring_id_d;
            buzz_q     <= buzz_d;
            snoozing_q <= snoozing_d;
            snooze_q   <= snooze_d;
            dismiss_q  <= dismiss_d;
        end
    end

    assign bus.buzz     = buzz_q;
    assign bus.ring_id  = ring_id_q;
    assign bus.snoozing = snoozing_q;

endmodule

// File: tb/tb_alarm_scheduler.sv
// Scoreboard bench for alarm_scheduler: stimulus queues expected outputs per cycle,
// a negedge monitor pops and compares them.
module tb_alarm_scheduler;

    logic clock = 1'b0;
    logic reset;

    alarm_scheduler_if bus ();

    alarm_scheduler #(
        .RING_SECS  (60),
        .SNOOZE_MIN (9),
        .MAX_SNOOZE (3)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        int unsigned cyc;
        logic        buzz;
        logic [1:0]  rid;
        logic        snz;
        string       tag;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned cyc     = 0;
    int          n_tests = 0;
    int          n_fail  = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: compare every expectation registered for the current cycle
    always @(negedge clock) begin
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            n_tests++;
            if (e.cyc != cyc) begin
                n_fail++;
                $display("FAIL %s: checked at cycle %0d, required cycle %0d", e.tag, cyc, e.cyc);
            end else if (bus.buzz !== e.buzz || bus.ring_id !== e.rid || bus.snoozing !== e.snz) begin
                n_fail++;
                $display("FAIL %s: got buzz=%0b ring_id=%b snoozing=%0b, expected buzz=%0b ring_id=%b snoozing=%0b",
                         e.tag, bus.buzz, bus.ring_id, bus.snoozing, e.buzz, e.rid, e.snz);
            end
        end
    end

    function automatic logic [15:0] t(input int h, input int m);
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
    endfunction

    task automatic step(input int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic expect_out(input logic b, input logic [1:0] r, input logic s, input string tag);
        exp_t e;
        e.cyc  = cyc;
        e.buzz = b;
        e.rid  = r;
        e.snz  = s;
        e.tag  = tag;
        exp_q.push_back(e);
    endtask

    task automatic set_ticks(input logic v);
        bus.sec_tick = v;
        bus.min_tick = v;
    endtask

    initial begin
        reset        = 1'b1;
        bus.sec_tick = 1'b0;
        bus.min_tick = 1'b0;
        bus.time_bcd = t(0, 0);
        bus.alarm1   = t(0, 0);
        bus.alarm2   = t(0, 0);
        bus.alm_en   = 2'b00;
        bus.snooze   = 1'b0;
        bus.dismiss  = 1'b0;
        step(2);
        expect_out(1'b0, 2'b00, 1'b0, "reset");

        // 1: ring at 07:30, auto-dismiss after 60 seconds
        reset        = 1'b0;
        bus.alarm1   = t(7, 30);
        bus.alm_en   = 2'b01;
        bus.time_bcd = t(7, 29);
        step();
        expect_out(1'b0, 2'b00, 1'b0, "t1_before_match");
        bus.time_bcd = t(7, 30);
        step();
        expect_out(1'b1, 2'b01, 1'b0, "t1_ring");
        for (int i = 0; i < 60; i++) begin
            bus.sec_tick = 1'b1;
            step();
            bus.sec_tick = 1'b0;
            if (i == 58) expect_out(1'b1, 2'b01, 1'b0, "t1_59_secs");
            if (i == 59) expect_out(1'b0, 2'b00, 1'b0, "t1_timeout");
            step();
        end
        step(3);
        expect_out(1'b0, 2'b00, 1'b0, "t1_no_retrigger");

        // 2: three honoured snoozes, fourth acts as dismiss
        bus.alarm1   = t(8, 0);
        bus.time_bcd = t(7, 59);
        step();
        bus.time_bcd = t(8, 0);
        step();
        expect_out(1'b1, 2'b01, 1'b0, "t2_ring");
        for (int r = 0; r < 3; r++) begin
            bus.snooze = 1'b1;
            step();
            expect_out(1'b0, 2'b01, 1'b1, "t2_snooze");
            bus.snooze = 1'b0;
            step();
            for (int i = 0; i < 9; i++) begin
                set_ticks(1'b1);
                step();
                set_ticks(1'b0);
                if (i == 7) expect_out(1'b0, 2'b01, 1'b1, "t2_8_mins");
                if (i == 8) expect_out(1'b1, 2'b01, 1'b0, "t2_rering");
                step();
            end
        end
        bus.snooze = 1'b1;
        step();
        expect_out(1'b0, 2'b00, 1'b0, "t2_4th_snooze");
        bus.snooze = 1'b0;
        step();

        // 3: both alarms at 06:00, alarm 1 wins, alarm 2 not queued
        bus.alarm1   = t(6, 0);
        bus.alarm2   = t(6, 0);
        bus.alm_en   = 2'b11;
        bus.time_bcd = t(5, 59);
        step();
        bus.time_bcd = t(6, 0);
        step();
        expect_out(1'b1, 2'b01, 1'b0, "t3_a1_wins");
        bus.dismiss = 1'b1;
        step();
        expect_out(1'b0, 2'b00, 1'b0, "t3_dismiss");
        bus.dismiss = 1'b0;
        step(3);
        expect_out(1'b0, 2'b00, 1'b0, "t3_no_a2_ring");

        // 4: manual set back to 06:00 re-arms
        bus.time_bcd = t(6, 1);
        step();
        bus.time_bcd = t(6, 0);
        step();
        expect_out(1'b1, 2'b01, 1'b0, "t4_reset_time_rings");
        step(2);
        expect_out(1'b1, 2'b01, 1'b0, "t4_hold");

        // 5: simultaneous snooze+dismiss, then disable during SNOOZE
        bus.snooze  = 1'b1;
        bus.dismiss = 1'b1;
        step();
        expect_out(1'b0, 2'b00, 1'b0, "t5_both_edges");
        bus.snooze   = 1'b0;
        bus.dismiss  = 1'b0;
        bus.time_bcd = t(6, 1);
        step();
        bus.time_bcd = t(6, 0);
        step();
        expect_out(1'b1, 2'b01, 1'b0, "t5_ring");
        bus.snooze = 1'b1;
        step();
        expect_out(1'b0, 2'b01, 1'b1, "t5_snooze");
        bus.snooze = 1'b0;
        bus.alm_en = 2'b10;
        step();
        expect_out(1'b0, 2'b00, 1'b0, "t5_disable");
        step(2);
        expect_out(1'b0, 2'b00, 1'b0, "t5_a2_dropped");

        // 6: reset mid-RING, then midnight rollover onto alarm 2
        bus.alm_en   = 2'b01;
        bus.alarm1   = t(12, 0);
        bus.time_bcd = t(11, 59);
        step();
        bus.time_bcd = t(12, 0);
        step();
        expect_out(1'b1, 2'b01, 1'b0, "t6_ring");
        reset        = 1'b1;
        bus.time_bcd = t(12, 1);
        step();
        expect_out(1'b0, 2'b00, 1'b0, "t6_reset");
        step();
        expect_out(1'b0, 2'b00, 1'b0, "t6_reset_hold");
        reset        = 1'b0;
        bus.alarm2   = t(0, 0);
        bus.alm_en   = 2'b10;
        bus.time_bcd = t(23, 59);
        step();
        expect_out(1'b0, 2'b00, 1'b0, "t6_2359");
        bus.time_bcd = t(0, 0);
        step();
        expect_out(1'b1, 2'b10, 1'b0, "t6_midnight");
        bus.dismiss = 1'b1;
        step();
        expect_out(1'b0, 2'b00, 1'b0, "t6_dismiss");
        bus.dismiss = 1'b0;

        step(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
